// File: rtl/multiplier_seq_ctrl.sv
// Iterative unsigned N x N shift-and-add multiplier controller.
// One N-bit adder row is reused each cycle, consuming one multiplier bit
// (LSB first) per clock. The product is registered and held until the sink
// accepts it.
module multiplier_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mplr_q, mplr_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     acc_hi_q, acc_hi_d;
  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [2*N-1:0]   p_q, p_d;
  logic [N:0]       sum;

  // Next-state and datapath: one partial-product row per RUN cycle.
  always_comb begin
    sum         = {1'b0, acc_hi_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    state_d     = state_q;
    mplr_d      = mplr_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    p_d         = p_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mplr_d   = a;
          mcand_d  = b;
          acc_hi_d = '0;
          acc_lo_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = sum[N:1];
        acc_lo_d = {sum[0], acc_lo_q[N-1:1]};
        mplr_d   = mplr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Capture the final shifted accumulator straight into the output register.
          p_d         = {sum[N:1], sum[0], acc_lo_q[N-1:1]};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // New operands are never taken here; only the sink handshake matters.
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State register; reset discards any partial result and clears the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mplr_q      <= '0;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      p_q         <= '0;
    end else begin
      state_q     <= state_d;
      mplr_q      <= mplr_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      p_q         <= p_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// Scoreboard bench for multiplier_seq_ctrl at N=4 and N=8.
module tb_multiplier_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv4, ir4, ov4, or4, bz4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic iv8, ir8, ov8, or8, bz8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  multiplier_seq_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .p(p4), .busy(bz4)
  );

  multiplier_seq_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .p(p8), .busy(bz8)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model state: busy, done, remaining RUN cycles, last delivered product.
  longint q4[$];
  longint q8[$];
  bit mb4, md4, acc4, sp_chk;
  bit mb8, md8, acc8;
  int ml4, ml8, last_acc4;
  longint lp4, lp8;

  // Behavioural model: accept when idle, N cycles of work, then wait for sink.
  always @(posedge clk) begin
    cyc++;
    acc4 = 0;
    acc8 = 0;
    if (rst) begin
      mb4 = 0; md4 = 0; ml4 = 0; lp4 = 0; q4.delete();
      mb8 = 0; md8 = 0; ml8 = 0; lp8 = 0; q8.delete();
    end else begin
      if (!mb4) begin
        if (iv4) begin
          mb4 = 1; ml4 = 4; acc4 = 1;
          q4.push_back(longint'(a4) * longint'(b4));
          if (sp_chk) chk("spacing4", cyc - last_acc4, 6);
          last_acc4 = cyc;
        end
      end else if (!md4) begin
        ml4--;
        if (ml4 == 0) md4 = 1;
      end else if (or4) begin
        md4 = 0; mb4 = 0;
      end
      if (!mb8) begin
        if (iv8) begin
          mb8 = 1; ml8 = 8; acc8 = 1;
          q8.push_back(longint'(a8) * longint'(b8));
        end
      end else if (!md8) begin
        ml8--;
        if (ml8 == 0) md8 = 1;
      end else if (or8) begin
        md8 = 0; mb8 = 0;
      end
    end
  end

  // Monitor for N=4: handshake flags against the model, product against the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready4", ir4, !mb4);
      chk("busy4", bz4, mb4);
      chk("out_valid4", ov4, md4);
      if (ov4) begin
        if (q4.size() == 0) begin
          checks++; failures++;
          $display("FAIL p4_unexpected actual=%0d expected=none cyc=%0d", p4, cyc);
        end else begin
          chk("p4", p4, q4[0]);
          if (or4) begin
            lp4 = q4.pop_front();
            $display("N4 txn p=%0d expected=%0d cyc=%0d", p4, lp4, cyc);
          end
        end
      end else begin
        chk("p4_hold", p4, lp4);
      end
    end
  end

  // Monitor for N=8.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready8", ir8, !mb8);
      chk("busy8", bz8, mb8);
      chk("out_valid8", ov8, md8);
      if (ov8) begin
        if (q8.size() == 0) begin
          checks++; failures++;
          $display("FAIL p8_unexpected actual=%0d expected=none cyc=%0d", p8, cyc);
        end else begin
          chk("p8", p8, q8[0]);
          if (or8) begin
            lp8 = q8.pop_front();
            $display("N8 txn p=%0d expected=%0d cyc=%0d", p8, lp8, cyc);
          end
        end
      end else begin
        chk("p8_hold", p8, lp8);
      end
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit keep);
    bit got;
    got = 0;
    iv4 = 1; a4 = a; b4 = b;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc4) begin got = 1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept4_timeout actual=0 expected=1 cyc=%0d", cyc);
    end
    if (!keep) iv4 = 0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 0;
    iv8 = 1; a8 = a; b8 = b;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc8) begin got = 1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept8_timeout actual=0 expected=1 cyc=%0d", cyc);
    end
    iv8 = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!mb4 && !mb8) break;
      @(posedge clk); #1;
    end
    if (mb4 || mb8) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=busy expected=idle cyc=%0d", cyc);
    end
  endtask

  initial begin
    rst = 1;
    iv4 = 0; a4 = '0; b4 = '0; or4 = 1;
    iv8 = 0; a8 = '0; b8 = '0; or8 = 1;
    sp_chk = 0;
    @(posedge clk); #1;
    chk_en = 1;
    iv4 = 1; iv8 = 1;              // in_valid during reset must be ignored
    @(posedge clk); #1;
    iv4 = 0; iv8 = 0;
    rst = 0;

    // Basic product and latency
    op4(4'd13, 4'd11, 0);
    wait_idle();

    // Extremes back to back
    op4(4'd15, 4'd15, 0);
    op4(4'd0, 4'd9, 0);
    wait_idle();

    // Backpressure: product held, stray in_valid pulses ignored
    or4 = 0;
    op4(4'd7, 4'd6, 0);
    for (int i = 0; i < 20; i++) begin
      if (md4) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      iv4 = ~iv4; a4 = 4'd1; b4 = 4'd1;
    end
    iv4 = 0;
    or4 = 1;
    wait_idle();

    // Reset during the second RUN cycle
    op4(4'd9, 4'd9, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_p4", p4, 0);
    chk("rst_mid_ov4", ov4, 0);
    chk("rst_mid_busy4", bz4, 0);
    @(posedge clk); #1;
    op4(4'd3, 4'd5, 0);
    wait_idle();

    // Wider instance
    op8(8'd255, 8'd255);
    op8(8'd128, 8'd2);
    wait_idle();

    // Exhaustive N=4 with in_valid held high
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), 1);
        sp_chk = 1;
      end
    end
    iv4 = 0;
    sp_chk = 0;
    wait_idle();

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      iv4 = 1'($urandom_range(0, 1));
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      or4 = ($urandom_range(0, 9) < 7);
      iv8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      or8 = ($urandom_range(0, 9) < 7);
    end
    iv4 = 0; or4 = 1;
    iv8 = 0; or8 = 1;
    wait_idle();

    @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_seq_ctrl.md
Name: multiplier_seq_ctrl

Overview:
Iterative unsigned N×N multiplier controller. A single N-bit partial-product adder row (AND-gated multiplicand plus accumulator, ripple carry) is reused once per clock, one multiplier bit per cycle.
- Sequencer owns operand capture, shift/accumulate, bit counter and the valid/ready handshakes on both sides.
- Sits between an operand source and a result sink in the multiplier design family. It is the area-minimal alternative to the fully combinational array.

Parameters:
N, 4, operand width in bits; legal range 2..32.
CNT_W, $clog2(N), bit-counter width; derived, not overridden.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a  input  N  multiplier (unsigned), sampled on accept
b  input  N  multiplicand (unsigned), sampled on accept
out_valid  output  1  product valid
out_ready  input  1  sink accepts product
p  output  2N  product a*b (unsigned)
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, busy=0, p=0. All internal registers are zero: mplr, mcand, acc_hi, acc_lo, cnt.
- Reset mid-operation: on the next edge, return to IDLE and clear all state. A partial result is never presented. An in_valid high during rst is ignored.

State IDLE:
- in_ready=1, busy=0.
- If in_valid, the accept edge latches mplr<=a, mcand<=b, acc_hi<=0, acc_lo<=0, cnt<=0, and moves to RUN.

State RUN:
- in_ready=0, busy=1. Exactly N cycles per operation.
- Each edge computes sum[N:0] = acc_hi + (mplr[0] ? mcand : 0), with N+1 bits so there is no overflow.
- Updates on that edge:
  - acc_hi <= sum[N:1]
  - acc_lo <= {sum[0], acc_lo[N-1:1]}
  - mplr <= mplr>>1
  - cnt <= cnt+1
- When cnt==N-1 on an edge, that edge's update is applied and the state moves to DONE.

State DONE:
- out_valid=1, busy=1, in_ready=0.
- p={acc_hi,acc_lo}, registered and stable while out_valid && !out_ready.
- If out_ready, go to IDLE on that edge. out_valid falls the cycle after the handshake.

Handshake and timing:
- Latency: out_valid is asserted N cycles after the accept edge, i.e. the first cycle after the N-th RUN edge.
- Minimum initiation interval: N+2 cycles (accept, N RUN, DONE with out_ready=1, IDLE).
- in_valid and a/b are ignored while busy. There is no queuing and no overlap.

Output and arithmetic rules:
- p keeps its last value after the handshake until overwritten at the next RUN completion. Sinks must qualify p with out_valid.
- Arithmetic is unsigned and exact: p = a*b, max (2^N-1)^2 fits in 2N bits, and there is no truncation.
- Operand zero gets no early termination: zero operands still take N cycles.
- Simultaneous in_valid and out_ready in DONE: only out_ready acts. The new operands are accepted no earlier than the following IDLE cycle.

Test Plan:
1. N=4, reset then a=13, b=11, in_valid one cycle, out_ready=1 -> in_ready low for 5 cycles; out_valid rises 4 cycles after accept with p=143 (0x8F); back in IDLE 1 cycle later.
2. N=4, a=15, b=15 followed by a=0, b=9 -> p=225 (0xE1), then p=0. Each out_valid arrives exactly 4 cycles after its accept.
3. N=4 backpressure: a=7, b=6, out_ready=0 for 10 cycles, then 1 -> p=42 held constant and out_valid high for all 10 cycles; one handshake only; in_valid pulses with a=1, b=1 during the stall are not accepted (in_ready=0).
4. N=4, rst asserted for 1 cycle at the 2nd RUN cycle of a=9, b=9 -> next cycle state IDLE, out_valid=0, p=0, busy=0. The following op a=3, b=5 gives p=15.
5. N=8, a=255, b=255 -> p=65025 (0xFE01) after 8 cycles; then a=128, b=2 -> p=256.
6. N=4 exhaustive: all 256 (a,b) pairs back-to-back, in_valid held high, out_ready=1 -> every p equals a*b; accept-to-accept spacing exactly 6 cycles.
